bcd_timer_ctrl: RTL and testbench
=================================

// Module: bcd_timer_ctrl
// PURPOSE
//   Sequencing controller for a cascaded multi-digit BCD (decade) down-counter.
//   Loads a BCD preset, then decrements it once per prescaled tick under start/stop/clear commands.
//   Flags terminal count with a one-cycle done pulse.
//   Sits between the panel/command logic and the display decoder; count drives the digits directly.
// PARAMETERS
//   DIGITS    4   number of cascaded BCD digits; count width = 4*DIGITS
//   PRESCALE  10  clk cycles per count tick (>=1); prescaler width = clog2(PRESCALE), min 1
// PORTS
//   clk     in   1         clock, all state updates on posedge
//   rst     in   1         reset, asynchronous, active-low
//   start   in   1         run/resume command (level, sampled each cycle)
//   stop    in   1         pause command
//   clear   in   1         abort: count<=0, return to IDLE
//   load    in   1         copy preset into count (not honoured in RUN)
//   preset  in   4*DIGITS  BCD preset, digit 0 in [3:0]
//   count   out  4*DIGITS  current BCD count
//   state   out  2         00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   busy    out  1         1 iff state==RUN
//   done    out  1         one-cycle pulse on the tick that reaches zero
// BEHAVIOUR
//   Reset (rst=0, async): count=0, state=IDLE, prescaler=0, busy=0, done=0.
//   Command priority per cycle: clear > load > stop > start. Exactly one command acts per edge.
//   All commands are registered: state/count change on the edge that samples them (1-cycle latency).
//   clear: any state -> IDLE; count=0; prescaler=0; done=0 that cycle.
//   load:
//     - IDLE/PAUSE/DONE -> IDLE; count=preset, each digit >9 saturated to 9; prescaler=0.
//     - RUN: ignored; lower-priority commands in the same cycle still evaluated.
//   start:
//     - IDLE with count!=0 -> RUN, prescaler restarts at 0.
//     - PAUSE with count!=0 -> RUN, prescaler phase preserved.
//     - count==0 or DONE: ignored.
//   stop: RUN -> PAUSE; prescaler and count frozen. Ignored in other states.
//   Prescaler:
//     - counts 0..PRESCALE-1 only in RUN.
//     - tick = (state==RUN && prescaler==PRESCALE-1); prescaler wraps to 0 on tick.
//     - PRESCALE=1: tick every RUN cycle.
//   On tick (no clear/stop that cycle): BCD decrement.
//     - Digit 0 minus 1. A digit at 0 becomes 9 and borrows from the next digit.
//     - Borrow ripples across all digits combinationally within the cycle.
//   Stop or clear coincident with a tick wins; no decrement occurs.
//   Tick taking count 1 -> 0: state -> DONE, done=1 for exactly that edge's following cycle.
//   count never wraps below 0.
//   DONE holds count=0 and busy=0 until clear or load.
//   busy and state are registered, coherent with count. No combinational path from inputs to outputs.
//   Mid-operation async reset: immediate return to reset values; no done pulse.
// TESTING
//   1. Reset: assert rst=0 for 2 cycles -> count=0000, state=00, busy=0, done=0.
//   2. PRESCALE=3, load 0x0012, start:
//      - count 0011 after 3 cycles; 0010 -> 0009 borrow.
//      - done pulses once after 36 RUN cycles; state=11, count=0000.
//   3. Load 0x1000, start, one tick -> 0999; load 0x00AF -> count=0099 (digit saturation).
//   4. Stop while prescaler=1 (PRESCALE=3), hold 5 cycles with count unchanged, start:
//      next decrement exactly 2 cycles after resume.
//   5. Simultaneous stop+start while in RUN -> PAUSE.
//      Load in RUN -> ignored. Start with count=0000 in IDLE -> stays IDLE.
//   6. clear coincident with a tick in RUN -> count=0000, IDLE, done=0.
//      rst=0 mid-run -> immediate reset values.

Source files
------------

// File: rtl/bcd_timer_if.sv
// bcd_timer_if: command/status bundle between panel logic and the BCD timer controller
interface bcd_timer_if #(parameter int DIGITS = 4);
  logic start, stop, clear, load;
  logic [4*DIGITS-1:0] preset, count;
  logic [1:0] state;
  logic busy, done;
  modport master(output start, stop, clear, load, preset, input count, state, busy, done);
  modport slave(input start, stop, clear, load, preset, output count, state, busy, done);
endinterface

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: prescaled multi-digit BCD down-counter with start/stop/clear/load sequencing
module bcd_timer_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input logic        clk,
  input logic        rst,
  bcd_timer_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  state_t state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [PW-1:0] psc_q, psc_d;
  logic done_q, done_d, tick;
  function automatic logic [W-1:0] sat_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++) r[4*i+:4] = v[4*i+:4] > 4'd9 ? 4'd9 : v[4*i+:4];
    return r;
  endfunction
  // Borrow ripples from digit 0 upward; a zero digit under borrow becomes 9
  function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic b;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i+:4] = b ? (v[4*i+:4] == 4'd0 ? 4'd9 : v[4*i+:4] - 4'd1) : v[4*i+:4];
      b = b && v[4*i+:4] == 4'd0;
    end
    return r;
  endfunction
  assign tick = state_q == RUN && psc_q == PMAX;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    psc_d   = psc_q;
    done_d  = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
      psc_d   = '0;
    end else if (bus.load && state_q != RUN) begin
      state_d = IDLE;
      count_d = sat_bcd(bus.preset);
      psc_d   = '0;
    end else if (bus.stop && state_q == RUN) begin
      state_d = PAUSE;
    end else if (bus.start && (state_q == IDLE || state_q == PAUSE) && count_q != '0) begin
      state_d = RUN;
      psc_d   = state_q == IDLE ? '0 : psc_q;
    end else if (state_q == RUN) begin
      psc_d   = tick ? '0 : psc_q + 1'b1;
      count_d = tick ? dec_bcd(count_q) : count_q;
      state_d = tick && count_q == W'(1) ? DONE : RUN;
      done_d  = tick && count_q == W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      psc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      psc_q   <= psc_d;
      done_q  <= done_d;
    end
  end
  assign bus.count = count_q;
  assign bus.state = state_q;
  assign bus.busy  = state_q == RUN;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb_bcd_timer_ctrl: directed scenarios plus random commands against a decimal-arithmetic reference model
module tb_bcd_timer_ctrl;
  localparam int D = 4;
  localparam int P = 3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int m_cnt, m_st, m_ph, m_done;
  int pulses;
  bcd_timer_if #(.DIGITS(D)) bus();
  bcd_timer_ctrl #(.DIGITS(D), .PRESCALE(P)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int to_bcd(input int v);
    int r = 0;
    for (int i = 0; i < D; i++) begin
      r += (v % 10) << (4 * i);
      v /= 10;
    end
    return r;
  endfunction
  function automatic int sat_val(input int p);
    int r = 0, mul = 1, d;
    for (int i = 0; i < D; i++) begin
      d = (p >> (4 * i)) & 15;
      r += (d > 9 ? 9 : d) * mul;
      mul *= 10;
    end
    return r;
  endfunction
  task automatic model_reset();
    m_cnt = 0; m_st = 0; m_ph = 0; m_done = 0;
  endtask
  task automatic model_edge();
    bit tk;
    tk = m_st == 1 && m_ph == P - 1;
    m_done = 0;
    if (bus.clear) begin
      m_st = 0; m_cnt = 0; m_ph = 0;
    end else if (bus.load && m_st != 1) begin
      m_st = 0; m_cnt = sat_val(int'(bus.preset)); m_ph = 0;
    end else if (bus.stop && m_st == 1) begin
      m_st = 2;
    end else if (bus.start && (m_st == 0 || m_st == 2) && m_cnt != 0) begin
      if (m_st == 0) m_ph = 0;
      m_st = 1;
    end else if (m_st == 1) begin
      if (tk) begin
        m_ph = 0;
        m_cnt--;
        if (m_cnt == 0) begin m_st = 3; m_done = 1; end
      end else m_ph++;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(bus.count), 32'(to_bcd(m_cnt)));
    chk({tag, ".state"}, 32'(bus.state), 32'(m_st));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(m_st == 1));
    chk({tag, ".done"}, 32'(bus.done), 32'(m_done));
  endtask
  task automatic cmd(input string tag, input bit s, input bit t, input bit c, input bit l, input logic [15:0] p);
    bus.start = s; bus.stop = t; bus.clear = c; bus.load = l; bus.preset = p;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (bus.done) pulses++;
    check_all(tag);
  endtask
  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cmd(tag, 0, 0, 0, 0, 16'h0);
  endtask
  initial begin
    bus.start = 0; bus.stop = 0; bus.clear = 0; bus.load = 0; bus.preset = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    cmd("t2_load", 0, 0, 0, 1, 16'h0012);
    cmd("t2_start", 1, 0, 0, 0, 16'h0);
    idle("t2_run", 3);
    chk("t2_first_tick", 32'(bus.count), 32'h0011);
    idle("t2_run", 6);
    chk("t2_borrow", 32'(bus.count), 32'h0009);
    pulses = 0;
    idle("t2_run", 27);
    chk("t2_done_once", 32'(pulses), 1);
    chk("t2_done_state", 32'(bus.state), 32'h3);
    chk("t2_done_count", 32'(bus.count), 32'h0000);
    idle("t2_hold", 3);
    cmd("t3_load", 0, 0, 0, 1, 16'h1000);
    cmd("t3_start", 1, 0, 0, 0, 16'h0);
    idle("t3_run", 3);
    chk("t3_ripple", 32'(bus.count), 32'h0999);
    cmd("t3_stop", 0, 1, 0, 0, 16'h0);
    cmd("t3_sat", 0, 0, 0, 1, 16'h00AF);
    chk("t3_sat_val", 32'(bus.count), 32'h0099);
    cmd("t4_load", 0, 0, 0, 1, 16'h0050);
    cmd("t4_start", 1, 0, 0, 0, 16'h0);
    idle("t4_run", 1);
    cmd("t4_stop", 0, 1, 0, 0, 16'h0);
    idle("t4_hold", 5);
    chk("t4_frozen", 32'(bus.count), 32'h0050);
    cmd("t4_resume", 1, 0, 0, 0, 16'h0);
    idle("t4_wait", 1);
    chk("t4_not_yet", 32'(bus.count), 32'h0050);
    idle("t4_wait", 1);
    chk("t4_dec", 32'(bus.count), 32'h0049);
    cmd("t5_stopstart", 1, 1, 0, 0, 16'h0);
    chk("t5_pause", 32'(bus.state), 32'h2);
    cmd("t5_resume", 1, 0, 0, 0, 16'h0);
    cmd("t5_load_run", 0, 0, 0, 1, 16'h0777);
    chk("t5_load_ignored", 32'(bus.state), 32'h1);
    cmd("t5_clear", 0, 0, 1, 0, 16'h0);
    cmd("t5_start_zero", 1, 0, 0, 0, 16'h0);
    chk("t5_stay_idle", 32'(bus.state), 32'h0);
    cmd("t6_load", 0, 0, 0, 1, 16'h0005);
    cmd("t6_start", 1, 0, 0, 0, 16'h0);
    idle("t6_run", 2);
    cmd("t6_clear_tick", 0, 0, 1, 0, 16'h0);
    chk("t6_cnt", 32'(bus.count), 32'h0000);
    chk("t6_state", 32'(bus.state), 32'h0);
    chk("t6_done", 32'(bus.done), 32'h0);
    cmd("t6_load2", 0, 0, 0, 1, 16'h0321);
    cmd("t6_start2", 1, 0, 0, 0, 16'h0);
    idle("t6_run2", 4);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("t6_async_rst");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [15:0] p;
      r = $urandom_range(0, 99);
      p = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 31));
      cmd("rand", r < 35, r >= 90, r < 2, r >= 82 && r < 90 || r == 2, p);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
